// File: rtl/fcr_host_port_pkg.sv
// Shared definitions for the FCR host port: command word field layout,
// target/opcode constants, response error codes and the FSM state type.
package fcr_host_port_pkg;

    // Command word layout: {target[31:24], cmd[23:16], data[15:0]}
    localparam int TARGET_MSB = 31;
    localparam int TARGET_LSB = 24;
    localparam int CMD_MSB    = 23;
    localparam int CMD_LSB    = 16;
    localparam int DATA_MSB   = 15;
    localparam int DATA_LSB   = 0;

    localparam logic [7:0] C_TARGET_PHF     = 8'h03;
    localparam logic [7:0] C_PHF_CLEAR      = 8'h01;
    localparam logic [7:0] C_PHF_GET_STATUS = 8'h02;

    localparam logic [1:0] FCR_ERR_OK       = 2'b00;
    localparam logic [1:0] FCR_ERR_MISMATCH = 2'b01;
    localparam logic [1:0] FCR_ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_WAIT_RSP,
        ST_DELIVER
    } fcr_state_e;

    // Header = {target, cmd}, the part of a reply that must echo the command.
    function automatic logic [15:0] cmd_header(input logic [31:0] word);
        return {word[TARGET_MSB:TARGET_LSB], word[CMD_MSB:CMD_LSB]};
    endfunction

    function automatic logic [1:0] header_err(input logic [15:0] got,
                                              input logic [15:0] expected);
        return (got == expected) ? FCR_ERR_OK : FCR_ERR_MISMATCH;
    endfunction

endpackage

// File: rtl/fcr_host_port_if.sv
// Handshake bundle of the FCR host port: host command/response channels,
// the fcr-facing FIFO source/sink signals and the sticky protocol flag.
// master = host bridge + fcr side, slave = fcr_host_port.
interface fcr_host_port_if;
    logic [31:0] host_cmd_data;
    logic        host_cmd_valid;
    logic        host_cmd_ready;
    logic [31:0] host_rsp_data;
    logic [1:0]  host_rsp_err;
    logic        host_rsp_valid;
    logic        host_rsp_ready;
    logic [31:0] cmd_data;
    logic        cmd_waitreq;
    logic        cmd_rdreq;
    logic [31:0] rsp_data;
    logic        rsp_wrreq;
    logic        rsp_waitreq;
    logic        proto_err;

    modport master (
        output host_cmd_data, host_cmd_valid, host_rsp_ready,
               cmd_rdreq, rsp_data, rsp_wrreq,
        input  host_cmd_ready, host_rsp_data, host_rsp_err, host_rsp_valid,
               cmd_data, cmd_waitreq, rsp_waitreq, proto_err
    );

    modport slave (
        input  host_cmd_data, host_cmd_valid, host_rsp_ready,
               cmd_rdreq, rsp_data, rsp_wrreq,
        output host_cmd_ready, host_rsp_data, host_rsp_err, host_rsp_valid,
               cmd_data, cmd_waitreq, rsp_waitreq, proto_err
    );
endinterface

// File: rtl/fcr_host_fifo.sv
// Synchronous show-ahead command FIFO, 32 bits wide, 2**CMD_DEPTH_LOG2 deep.
// head is the oldest word whenever empty=0. ready is registered (!full), so a
// push offered while full is refused even if a pop happens on the same edge.
module fcr_host_fifo #(
    parameter int CMD_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        empty,
    output logic        ready
);
    localparam int DEPTH = 1 << CMD_DEPTH_LOG2;
    localparam logic [CMD_DEPTH_LOG2:0] DEPTH_CNT = (CMD_DEPTH_LOG2+1)'(DEPTH);

    logic [31:0]               mem [DEPTH];
    logic [CMD_DEPTH_LOG2-1:0] wr_ptr;
    logic [CMD_DEPTH_LOG2-1:0] rd_ptr;
    logic [CMD_DEPTH_LOG2:0]   count;
    logic [CMD_DEPTH_LOG2:0]   count_d;
    logic                      do_push;
    logic                      do_pop;

    assign do_push = push & ready;
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];
    assign empty   = (count == '0);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count - 1'b1;
        end
    end

    // Pointer, occupancy and registered-ready bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_d;
            ready <= (count_d != DEPTH_CNT);
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fcr_host_port.sv
// Host-side initiator for the FCR command/response FIFO interface.
// Queues host commands, offers them to fcr one at a time and returns exactly
// one tagged response (ok / header mismatch / timeout) per command.
// Optional feature macro: FCR_HOST_TIMEOUT_EN enables the response timeout
// (TIMEOUT_CYCLES); without it WAIT_RSP waits indefinitely.
module fcr_host_port
    import fcr_host_port_pkg::*;
#(
    parameter int CMD_DEPTH_LOG2 = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    fcr_host_port_if.slave    bus
);
    fcr_state_e  state, state_d;
    logic [31:0] cmd_data_d;
    logic        cmd_waitreq_d;
    logic        rsp_waitreq_d;
    logic [31:0] host_rsp_data_d;
    logic [1:0]  host_rsp_err_d;
    logic        host_rsp_valid_d;
    logic        proto_err_d;
    logic [15:0] exp_hdr, exp_hdr_d;

    logic [31:0] fifo_head;
    logic        fifo_empty;
    logic        fifo_ready;
    logic        fifo_pop;

`ifdef FCR_HOST_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] timer, timer_d;
`endif

    fcr_host_fifo #(
        .CMD_DEPTH_LOG2 (CMD_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.host_cmd_valid),
        .push_data (bus.host_cmd_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .ready     (fifo_ready)
    );

    assign bus.host_cmd_ready = fifo_ready;

    // Next state and next values of every registered output.
    always_comb begin
        state_d          = state;
        cmd_data_d       = bus.cmd_data;
        cmd_waitreq_d    = bus.cmd_waitreq;
        rsp_waitreq_d    = bus.rsp_waitreq;
        host_rsp_data_d  = bus.host_rsp_data;
        host_rsp_err_d   = bus.host_rsp_err;
        host_rsp_valid_d = bus.host_rsp_valid;
        exp_hdr_d        = exp_hdr;
        fifo_pop         = 1'b0;
        // A write while we are not accepting is dropped and flagged forever.
        proto_err_d      = bus.proto_err | (bus.rsp_wrreq & bus.rsp_waitreq);
`ifdef FCR_HOST_TIMEOUT_EN
        timer_d          = timer;
`endif
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d       = ST_PRESENT;
                    cmd_data_d    = fifo_head;
                    cmd_waitreq_d = 1'b0;
                end
            end
            ST_PRESENT: begin
                if (bus.cmd_rdreq) begin
                    fifo_pop      = 1'b1;
                    exp_hdr_d     = cmd_header(bus.cmd_data);
                    cmd_waitreq_d = 1'b1;
                    rsp_waitreq_d = 1'b0;
`ifdef FCR_HOST_TIMEOUT_EN
                    timer_d       = '0;
`endif
                    state_d       = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // A response on the expiring edge still takes the normal path.
                if (bus.rsp_wrreq && !bus.rsp_waitreq) begin
                    host_rsp_data_d  = bus.rsp_data;
                    host_rsp_err_d   = header_err(cmd_header(bus.rsp_data), exp_hdr);
                    host_rsp_valid_d = 1'b1;
                    rsp_waitreq_d    = 1'b1;
                    state_d          = ST_DELIVER;
                end
`ifdef FCR_HOST_TIMEOUT_EN
                else if (timer == TMR_LAST) begin
                    host_rsp_data_d  = {exp_hdr, 16'h0000};
                    host_rsp_err_d   = FCR_ERR_TIMEOUT;
                    host_rsp_valid_d = 1'b1;
                    rsp_waitreq_d    = 1'b1;
                    state_d          = ST_DELIVER;
                end else begin
                    timer_d = timer + 1'b1;
                end
`endif
            end
            ST_DELIVER: begin
                if (bus.host_rsp_ready) begin
                    host_rsp_valid_d = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered outputs; reset drops any outstanding command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            bus.cmd_data       <= '0;
            bus.cmd_waitreq    <= 1'b1;
            bus.rsp_waitreq    <= 1'b1;
            bus.host_rsp_data  <= '0;
            bus.host_rsp_err   <= FCR_ERR_OK;
            bus.host_rsp_valid <= 1'b0;
            bus.proto_err      <= 1'b0;
`ifdef FCR_HOST_TIMEOUT_EN
            timer              <= '0;
`endif
        end else begin
            state              <= state_d;
            bus.cmd_data       <= cmd_data_d;
            bus.cmd_waitreq    <= cmd_waitreq_d;
            bus.rsp_waitreq    <= rsp_waitreq_d;
            bus.host_rsp_data  <= host_rsp_data_d;
            bus.host_rsp_err   <= host_rsp_err_d;
            bus.host_rsp_valid <= host_rsp_valid_d;
            bus.proto_err      <= proto_err_d;
`ifdef FCR_HOST_TIMEOUT_EN
            timer              <= timer_d;
`endif
        end
    end

    // Expected reply header; only meaningful once a command has been popped.
    always_ff @(posedge clk) begin
        exp_hdr <= exp_hdr_d;
    end

endmodule

// File: tb/tb_fcr_host_port.sv
// Self-checking bench for fcr_host_port. The main process plays host and fcr;
// each issued command pushes its expected host response into a scoreboard that
// an independent monitor drains whenever a response handshake is presented.
module tb_fcr_host_port;
    import fcr_host_port_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [33:0] sb_q [$];
    logic [33:0] mon_exp;

    fcr_host_port_if bus ();

    fcr_host_port #(
        .CMD_DEPTH_LOG2 (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Response monitor: one comparison per presented handshake.
    always @(negedge clk) begin
        if (!rst && bus.host_rsp_valid && bus.host_rsp_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected actual=%h err=%b required=none",
                         bus.host_rsp_data, bus.host_rsp_err);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({bus.host_rsp_err, bus.host_rsp_data} !== mon_exp) begin
                    failures++;
                    $display("FAIL rsp_word actual=%h err=%b required=%h err=%b",
                             bus.host_rsp_data, bus.host_rsp_err,
                             mon_exp[31:0], mon_exp[33:32]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        int n = 0;
        bus.host_cmd_data  = w;
        bus.host_cmd_valid = 1'b1;
        while (!bus.host_cmd_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(bus.host_cmd_ready), 32'd1);
        tick();
        bus.host_cmd_valid = 1'b0;
    endtask

    task automatic pop_cmd(input logic [31:0] exp_cmd);
        int n = 0;
        while (bus.cmd_waitreq && n < 200) begin
            tick();
            n++;
        end
        chk("cmd_avail", 32'(bus.cmd_waitreq), 32'd0);
        chk("cmd_data", bus.cmd_data, exp_cmd);
        bus.cmd_rdreq = 1'b1;
        tick();
        bus.cmd_rdreq = 1'b0;
        chk("cmd_waitreq_after_pop", 32'(bus.cmd_waitreq), 32'd1);
        chk("rsp_waitreq_open", 32'(bus.rsp_waitreq), 32'd0);
    endtask

    task automatic reply(input logic [31:0] d);
        bus.rsp_data  = d;
        bus.rsp_wrreq = 1'b1;
        tick();
        bus.rsp_wrreq = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.host_rsp_valid && n < 200) begin
            tick();
            n++;
        end
        chk("rsp_done", 32'(bus.host_rsp_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.host_cmd_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.host_rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  bus.host_rsp_data, 32'd0);
        chk({tag, "_rsp_err"},   32'(bus.host_rsp_err), 32'd0);
        chk({tag, "_cmd_data"},  bus.cmd_data, 32'd0);
        chk({tag, "_cmd_waitreq"}, 32'(bus.cmd_waitreq), 32'd1);
        chk({tag, "_rsp_waitreq"}, 32'(bus.rsp_waitreq), 32'd1);
        chk({tag, "_proto_err"}, 32'(bus.proto_err), 32'd0);
    endtask

    logic [31:0] t3_cmd [5] = '{32'h0301_0010, 32'h0302_0011, 32'h0301_0012,
                                32'h0302_0013, 32'h0301_0014};
    logic [31:0] t3_rsp [5] = '{32'h0301_A000, 32'h0302_A001, 32'h0301_A002,
                                32'h0302_A003, 32'h0301_A004};

    initial begin
        bus.host_cmd_data  = '0;
        bus.host_cmd_valid = 1'b0;
        bus.host_rsp_ready = 1'b1;
        bus.cmd_rdreq      = 1'b0;
        bus.rsp_data       = '0;
        bus.rsp_wrreq      = 1'b0;

        // Reset values, ready rises one cycle after release
        repeat (3) tick();
        chk_reset_outputs("rst0");
        rst = 1'b0;
        chk("ready_before_rise", 32'(bus.host_cmd_ready), 32'd0);
        tick();
        chk("ready_after_rise", 32'(bus.host_cmd_ready), 32'd1);

        // 1: matching reply, cmd_waitreq low two edges after push
        push({C_TARGET_PHF, C_PHF_CLEAR, 16'd1});
        chk("t1_waitreq_edge_n", 32'(bus.cmd_waitreq), 32'd1);
        tick();
        chk("t1_waitreq_edge_n1", 32'(bus.cmd_waitreq), 32'd0);
        pop_cmd(32'h0301_0001);
        sb_q.push_back({FCR_ERR_OK, 32'h0301_0000});
        reply({C_TARGET_PHF, C_PHF_CLEAR, 16'd0});
        wait_done();

        // 2: header mismatch, response held while host stalls
        push({C_TARGET_PHF, C_PHF_GET_STATUS, 16'd1});
        pop_cmd(32'h0302_0001);
        bus.host_rsp_ready = 1'b0;
        sb_q.push_back({FCR_ERR_MISMATCH, 32'h03AA_1234});
        reply({C_TARGET_PHF, 8'hAA, 16'h1234});
        chk("t2_valid", 32'(bus.host_rsp_valid), 32'd1);
        tick();
        tick();
        chk("t2_valid_held", 32'(bus.host_rsp_valid), 32'd1);
        chk("t2_data_held", bus.host_rsp_data, 32'h03AA_1234);
        chk("t2_err_held", 32'(bus.host_rsp_err), 32'd1);
        bus.host_rsp_ready = 1'b1;
        wait_done();

        // 3: five back-to-back commands into a depth-4 queue
        for (int i = 0; i < 4; i++) push(t3_cmd[i]);
        chk("t3_full_ready", 32'(bus.host_cmd_ready), 32'd0);
        fork
            push(t3_cmd[4]);
            begin
                tick();
                tick();
                chk("t3_ready_held", 32'(bus.host_cmd_ready), 32'd0);
                for (int i = 0; i < 5; i++) begin
                    pop_cmd(t3_cmd[i]);
                    sb_q.push_back({FCR_ERR_OK, t3_rsp[i]});
                    reply(t3_rsp[i]);
                    wait_done();
                end
            end
        join

        // 5: stray write in IDLE
        chk("t5_proto_before", 32'(bus.proto_err), 32'd0);
        reply(32'hDEAD_BEEF);
        chk("t5_proto_set", 32'(bus.proto_err), 32'd1);
        repeat (4) tick();
        chk("t5_proto_sticky", 32'(bus.proto_err), 32'd1);
        chk("t5_no_rsp", 32'(bus.host_rsp_valid), 32'd0);

        // 6: reset while waiting for a reply with two queued
        push(32'h0301_0007);
        pop_cmd(32'h0301_0007);
        push(32'h0301_0008);
        push(32'h0302_0009);
        rst = 1'b1;
        tick();
        chk_reset_outputs("t6");
        tick();
        rst = 1'b0;
        tick();
        chk("t6_ready_back", 32'(bus.host_cmd_ready), 32'd1);
        repeat (4) tick();
        chk("t6_flushed", 32'(bus.cmd_waitreq), 32'd1);
        chk("t6_no_rsp", 32'(bus.host_rsp_valid), 32'd0);

`ifdef FCR_HOST_TIMEOUT_EN
        // 4: timeout after 16 WAIT_RSP cycles, late reply flags protocol error
        push({C_TARGET_PHF, C_PHF_GET_STATUS, 16'd5});
        pop_cmd(32'h0302_0005);
        sb_q.push_back({FCR_ERR_TIMEOUT, 32'h0302_0000});
        repeat (15) tick();
        chk("t4_not_yet", 32'(bus.host_rsp_valid), 32'd0);
        tick();
        chk("t4_timeout_valid", 32'(bus.host_rsp_valid), 32'd1);
        chk("t4_rsp_waitreq", 32'(bus.rsp_waitreq), 32'd1);
        wait_done();
        chk("t4_proto_clear", 32'(bus.proto_err), 32'd0);
        reply(32'h0302_0000);
        chk("t4_late_proto", 32'(bus.proto_err), 32'd1);
`else
        // 4: without the timeout the port waits for a reply indefinitely
        push({C_TARGET_PHF, C_PHF_GET_STATUS, 16'd5});
        pop_cmd(32'h0302_0005);
        repeat (40) tick();
        chk("t4_still_waiting", 32'(bus.host_rsp_valid), 32'd0);
        chk("t4_still_open", 32'(bus.rsp_waitreq), 32'd0);
        sb_q.push_back({FCR_ERR_OK, 32'h0302_0055});
        reply(32'h0302_0055);
        wait_done();
        chk("t4_proto_clear", 32'(bus.proto_err), 32'd0);
`endif

        repeat (3) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
